// File: rtl/hs_prod_gen.sv
// rtl/hs_prod_gen.sv - burst/gap valid-ready producer driven by a 16-bit Galois LFSR
// Optional macro HS_PROD_SEQ_EN: payload counts 0,1,2,... instead of sampling the LFSR.
module hs_prod_gen #(
  parameter int          DW        = 8,
  parameter int          BURST_MIN = 3,
  parameter int          BURST_MAX = 5,
  parameter int          GAP_MIN   = 1,
  parameter int          GAP_MAX   = 4,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          en,
  input  logic          rdy,
  output logic          val,
  output logic [DW-1:0] data,
  output logic [15:0]   xfer_cnt
);

  localparam int          B_SPAN   = BURST_MAX - BURST_MIN + 1;
  localparam int          G_SPAN   = GAP_MAX - GAP_MIN + 1;
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t        state_q;
  logic [7:0]    b_q;
  logic [7:0]    g_q;
  logic [15:0]   lfsr_q;
  logic [15:0]   lfsr_d;
  logic [7:0]    b_new;
  logic [7:0]    g_new;
  logic [DW-1:0] data_d;
  logic          accept;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign b_new  = 8'(BURST_MIN + (int'(lfsr_q[7:0]) % B_SPAN));
  assign g_new  = 8'(GAP_MIN + (int'(lfsr_q[15:8]) % G_SPAN));
  assign accept = val && rdy;

`ifdef HS_PROD_SEQ_EN
  assign data_d = data + DW'(1);
`else
  assign data_d = lfsr_q[DW-1:0];
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      val      <= 1'b0;
      data     <= '0;
      xfer_cnt <= 16'h0000;
      b_q      <= 8'd0;
      g_q      <= 8'd0;
      lfsr_q   <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
      if (accept) begin
        data <= data_d;
        if (xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
      end
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= BURST;
            val     <= 1'b1;
            b_q     <= b_new;
          end
        end
        BURST: begin
          // a pending beat is never withdrawn, even with en low
          if (accept) begin
            if (!en) begin
              state_q <= IDLE;
              val     <= 1'b0;
              b_q     <= 8'd0;
            end else if (b_q == 8'd1) begin
              if (g_new != 8'd0) begin
                state_q <= GAP;
                val     <= 1'b0;
                g_q     <= g_new;
                b_q     <= 8'd0;
              end else begin
                b_q <= b_new;
              end
            end else begin
              b_q <= b_q - 8'd1;
            end
          end
        end
        GAP: begin
          if (!en) begin
            state_q <= IDLE;
            g_q     <= 8'd0;
          end else if (g_q == 8'd1) begin
            state_q <= BURST;
            val     <= 1'b1;
            b_q     <= b_new;
            g_q     <= 8'd0;
          end else begin
            g_q <= g_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          val     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_prod_gen.sv
// tb/tb_hs_prod_gen.sv - self-checking bench for hs_prod_gen (three parameterisations)
module tb_hs_prod_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic        en_a, rdy_a, en_b, rdy_b, en_c, rdy_c;
  logic        val_a, val_b, val_c;
  logic [7:0]  data_a, data_c;
  logic [3:0]  data_b;
  logic [15:0] xc_a, xc_b, xc_c;

  hs_prod_gen #(.DW(8), .BURST_MIN(3), .BURST_MAX(3), .GAP_MIN(2), .GAP_MAX(2)) u_a (
    .clk(clk), .rst_b(rst_b), .en(en_a), .rdy(rdy_a),
    .val(val_a), .data(data_a), .xfer_cnt(xc_a));

  hs_prod_gen #(.DW(4), .BURST_MIN(3), .BURST_MAX(3), .GAP_MIN(0), .GAP_MAX(0)) u_b (
    .clk(clk), .rst_b(rst_b), .en(en_b), .rdy(rdy_b),
    .val(val_b), .data(data_b), .xfer_cnt(xc_b));

  hs_prod_gen #(.DW(8), .BURST_MIN(3), .BURST_MAX(5), .GAP_MIN(1), .GAP_MAX(4)) u_c (
    .clk(clk), .rst_b(rst_b), .en(en_c), .rdy(rdy_c),
    .val(val_c), .data(data_c), .xfer_cnt(xc_c));

  int n_asrt = 0;
  int n_fail = 0;

  // reference state: LFSR image, expected payloads, expected counts, run lengths
  logic [15:0] ml;
  logic [7:0]  de_a, de_c;
  logic [3:0]  de_b;
  logic [15:0] ce_a, ce_b, ce_c;
  int          bl, gl, n_bursts;
  bit          seen_gap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic model_reset();
    ml = 16'hACE1;
    de_a = 8'd0; de_b = 4'd0; de_c = 8'd0;
    ce_a = 16'd0; ce_b = 16'd0; ce_c = 16'd0;
    bl = 0; gl = 0; seen_gap = 1'b0;
  endtask

  // one clock: sample handshakes before the edge, update the reference, check after
  task automatic tick();
    logic acc_a, acc_b, acc_c, st_a, st_b, st_c, pv_c, r0;
    logic [15:0] l0;
    acc_a = val_a && rdy_a; st_a = val_a && !rdy_a;
    acc_b = val_b && rdy_b; st_b = val_b && !rdy_b;
    acc_c = val_c && rdy_c; st_c = val_c && !rdy_c;
    pv_c = val_c; l0 = ml; r0 = rst_b;
    @(posedge clk);
    if (r0) ml = {1'b0, ml[15:1]} ^ (ml[0] ? 16'hB400 : 16'h0000);
    #1;
`ifdef HS_PROD_SEQ_EN
    if (acc_a) de_a = de_a + 8'd1;
    if (acc_b) de_b = de_b + 4'd1;
    if (acc_c) de_c = de_c + 8'd1;
`else
    if (acc_a) de_a = l0[7:0];
    if (acc_b) de_b = l0[3:0];
    if (acc_c) de_c = l0[7:0];
`endif
    if (acc_a) ce_a = sat_inc(ce_a);
    if (acc_b) ce_b = sat_inc(ce_b);
    if (acc_c) ce_c = sat_inc(ce_c);
    chk("a_data", data_a, de_a);  chk("a_xfer", xc_a, ce_a);
    chk("b_data", data_b, de_b);  chk("b_xfer", xc_b, ce_b);
    chk("c_data", data_c, de_c);  chk("c_xfer", xc_c, ce_c);
    if (st_a) chk("a_hold_val", val_a, 1);
    if (st_b) chk("b_hold_val", val_b, 1);
    if (st_c) chk("c_hold_val", val_c, 1);
    if (acc_c) bl++;
    if (pv_c && !val_c) begin
      chk("c_burst_len", (bl >= 3 && bl <= 5), 1);
      n_bursts++;
      bl = 0; gl = 1; seen_gap = 1'b1;
    end else if (!pv_c && val_c) begin
      if (seen_gap) chk("c_gap_len", (gl >= 1 && gl <= 4), 1);
      gl = 0;
    end else if (!val_c) begin
      gl++;
    end
    @(negedge clk);
  endtask

  logic [7:0] held;

  initial begin
    rst_b = 1'b0;
    en_a = 1'b0; rdy_a = 1'b0; en_b = 1'b0; rdy_b = 1'b0; en_c = 1'b0; rdy_c = 1'b0;
    n_bursts = 0;
    model_reset();
    @(negedge clk);
    chk("rst_val_a", val_a, 0); chk("rst_data_a", data_a, 0); chk("rst_xfer_a", xc_a, 0);
    chk("rst_val_b", val_b, 0); chk("rst_val_c", val_c, 0);
    repeat (2) tick();
    rst_b = 1'b1;
    tick();
    chk("idle_no_en", val_a, 0);

    // start a burst, then yank reset between edges
    en_a = 1'b1; rdy_a = 1'b1;
    repeat (3) tick();
    #2;
    rst_b = 1'b0;
    #1;
    chk("async_rst_val", val_a, 0);
    chk("async_rst_data", data_a, 0);
    chk("async_rst_xfer", xc_a, 0);
    model_reset();
    @(negedge clk);
    tick();
    rst_b = 1'b1;

    // fixed 3-beat bursts with 2-cycle gaps
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("a_val_pattern", val_a, ((k - 1) % 5 < 3) ? 1 : 0);
      if (k == 1) chk("first_beat_data", data_a, 0);
    end
    chk("a_xfer_two_bursts", xc_a, 6);

    // stall the second beat of the next burst
    tick();
    chk("a_burst_start", val_a, 1);
    tick();
    held = data_a;
    rdy_a = 1'b0;
    repeat (4) begin
      tick();
      chk("a_stall_val", val_a, 1);
      chk("a_stall_data", data_a, held);
    end
    rdy_a = 1'b1;
    tick();
    chk("a_after_stall_val", val_a, 1);
    tick();
    chk("a_burst_end", val_a, 0);
    chk("a_xfer_three_more", xc_a, 9);

    // en low in GAP: IDLE, never resumes
    en_a = 1'b0;
    repeat (3) begin
      tick();
      chk("a_gap_to_idle", val_a, 0);
    end

    // en low with a beat pending: beat held until taken, then IDLE
    en_a = 1'b1; rdy_a = 1'b0;
    tick();
    chk("a_pend_start", val_a, 1);
    en_a = 1'b0;
    repeat (2) begin
      tick();
      chk("a_pend_hold", val_a, 1);
    end
    rdy_a = 1'b1;
    tick();
    chk("a_pend_taken_idle", val_a, 0);
    chk("a_pend_xfer", xc_a, 10);
    tick();
    chk("a_stays_idle", val_a, 0);
    rdy_a = 1'b0;

    // zero-gap bursts on a 4-bit payload: val never drops, payload wraps
    en_b = 1'b1; rdy_b = 1'b1;
    repeat (41) begin
      tick();
      chk("b_val_const", val_b, 1);
    end

    // randomized ready against run-length bounds
    en_c = 1'b1;
    repeat (10000) begin
      rdy_c = 1'($urandom_range(0, 1));
      tick();
    end
    chk("c_xfer_total", xc_c, ce_c);
    chk("c_bursts_seen", (n_bursts > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
